vec_ratio_div: RTL

//  Upstream feeder for the arctan stage: takes a signed Cartesian vector (x,y),

---
 rtl/vec_ratio_div_pkg.sv | 31 +++
 rtl/vec_ratio_div_if.sv | 37 +++
 rtl/vec_ratio_div_udiv_step.sv | 35 +++
 rtl/vec_ratio_div.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/vec_ratio_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vec_ratio_div_pkg
//  Description : Shared types and constants for the vector-ratio divider that
//                feeds the arctan stage. Holds the fixed-point fraction width,
//                the radians-to-degrees factor, the divider state enum and the
//                x==0 saturation helper.
//  Revision    : 1.0  initial release
// ============================================================================
package vec_ratio_div_pkg;

   // Fraction bits of z; must match the arctan stage input scaling
   localparam int FRAC_Q = 8;

   // Degrees per radian
   localparam real RAD2DEG = 57.29577951308232;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // Magnitude reported when x==0 and y!=0: all ones over the quotient width,
   // large enough that arctan lands at about +/-90 degrees.
   function automatic logic [63:0] zsat(input int width, input int frac);
      return (64'd1 << (width + frac)) - 64'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vec_ratio_div_if.sv
`default_nettype none
// ============================================================================
//  Module      : vec_ratio_div_if
//  Description : Operand and result handshake bundle for vec_ratio_div.
//                master = producer of x/y and consumer of z (upstream/downstream
//                side), slave = the divider itself.
//  Signals     : in_valid/in_ready/x/y      operand channel
//                out_valid/out_ready/z      result channel
//                x_neg/y_neg/x_zero         quadrant flags travelling with z
//  Revision    : 1.0  initial release
// ============================================================================
interface vec_ratio_div_if #(
   parameter int WIDTH = 16,
   parameter int ZW    = 32
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] x;
   logic signed [WIDTH-1:0] y;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [ZW-1:0]    z;
   logic                    x_neg;
   logic                    y_neg;
   logic                    x_zero;

   modport master (
      output in_valid, x, y, out_ready,
      input  in_ready, out_valid, z, x_neg, y_neg, x_zero
   );

   modport slave (
      input  in_valid, x, y, out_ready,
      output in_ready, out_valid, z, x_neg, y_neg, x_zero
   );
endinterface
`default_nettype wire

// File: rtl/vec_ratio_div_udiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : vec_ratio_div_udiv_step
//  Description : One combinational restoring-division step. Shifts the next
//                dividend bit into the partial remainder and subtracts the
//                divisor when it fits.
//  Ports       : rem_i      partial remainder in (always < divisor_i)
//                divisor_i  unsigned divisor
//                bit_i      next dividend bit, MSB first
//                rem_o      partial remainder out
//                q_bit_o    quotient bit produced by this step
//  Revision    : 1.0  initial release
// ============================================================================
module vec_ratio_div_udiv_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic             bit_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_bit_o
);
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;

   always_comb begin
      shifted = {rem_i, bit_i};
      q_bit_o = (shifted >= {1'b0, divisor_i});
      // When the divisor fits, the true difference is below the divisor, so
      // modulo-2^WIDTH arithmetic on the low bits gives the exact result.
      diff    = shifted[WIDTH-1:0] - divisor_i;
      rem_o   = q_bit_o ? diff : shifted[WIDTH-1:0];
   end
endmodule
`default_nettype wire

// File: rtl/vec_ratio_div.sv
`default_nettype none
// ============================================================================
//  Module      : vec_ratio_div
//  Description : Computes z = y/x in signed fixed point (FRAC fraction bits)
//                with a bit-serial restoring divider, one quotient bit per
//                clock, for the downstream arctan stage. Signs are stripped
//                on accept and re-applied to the truncated magnitude, so the
//                result rounds toward zero. x==0 bypasses the divider and
//                returns a saturated z with x_zero set.
//  Ports       : clk     clock, all state on posedge
//                rst     asynchronous active-high reset
//                bus_io  slave side of vec_ratio_div_if (operands, result,
//                        quadrant flags)
//  Revision    : 1.0  initial release
// ============================================================================
module vec_ratio_div
   import vec_ratio_div_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int FRAC  = FRAC_Q,
   parameter int ZW    = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   vec_ratio_div_if.slave       bus_io
);
   localparam int NB = WIDTH + FRAC;     // quotient bits = DIV cycles
   localparam int CW = $clog2(NB);

   div_state_t state_q, state_d;

   logic [CW-1:0]        cnt_q;
   // Dividend shifts out MSB-first while quotient bits shift in at the LSB;
   // after NB steps the register holds the quotient magnitude.
   logic [NB-1:0]        dvd_q;
   logic [WIDTH-1:0]     rem_q;
   logic [WIDTH-1:0]     dvs_q;
   logic                 xs_q, ys_q;
   logic signed [ZW-1:0] z_q;
   logic                 x_neg_q, y_neg_q, x_zero_q;

   logic [WIDTH-1:0]     x_mag, y_mag;
   logic [WIDTH-1:0]     step_rem;
   logic                 step_q;
   logic [NB-1:0]        quo_next;
   logic [ZW-1:0]        mag_ext;
   logic [ZW-1:0]        sat_mag;

   // Magnitudes as unsigned WIDTH bits so the most negative input is exact
   always_comb begin
      x_mag = bus_io.x[WIDTH-1] ? (WIDTH'(0) - $unsigned(bus_io.x)) : $unsigned(bus_io.x);
      y_mag = bus_io.y[WIDTH-1] ? (WIDTH'(0) - $unsigned(bus_io.y)) : $unsigned(bus_io.y);
   end

   vec_ratio_div_udiv_step #(
      .WIDTH     (WIDTH)
   ) u_step (
      .rem_i     (rem_q),
      .divisor_i (dvs_q),
      .bit_i     (dvd_q[NB-1]),
      .rem_o     (step_rem),
      .q_bit_o   (step_q)
   );

   always_comb begin
      quo_next = {dvd_q[NB-2:0], step_q};
      mag_ext  = ZW'(quo_next);
      sat_mag  = ZW'(zsat(WIDTH, FRAC));
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus_io.in_valid) state_d = (bus_io.x == '0) ? DONE : DIV;
         DIV:     if (cnt_q == '0)     state_d = DONE;
         DONE:    if (bus_io.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      bus_io.in_ready  = (state_q == IDLE);
      bus_io.out_valid = (state_q == DONE);
   end

   assign bus_io.z      = z_q;
   assign bus_io.x_neg  = x_neg_q;
   assign bus_io.y_neg  = y_neg_q;
   assign bus_io.x_zero = x_zero_q;

   // ---------------- Datapath ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         dvd_q    <= '0;
         rem_q    <= '0;
         dvs_q    <= '0;
         xs_q     <= 1'b0;
         ys_q     <= 1'b0;
         z_q      <= '0;
         x_neg_q  <= 1'b0;
         y_neg_q  <= 1'b0;
         x_zero_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus_io.in_valid) begin
                  dvs_q <= x_mag;
                  dvd_q <= {y_mag, {FRAC{1'b0}}};
                  rem_q <= '0;
                  cnt_q <= CW'(NB - 1);
                  xs_q  <= bus_io.x[WIDTH-1];
                  ys_q  <= bus_io.y[WIDTH-1];
                  // Divide by zero: result is published on this very edge
                  if (bus_io.x == '0) begin
                     x_zero_q <= 1'b1;
                     x_neg_q  <= 1'b0;
                     y_neg_q  <= bus_io.y[WIDTH-1];
                     if (bus_io.y == '0)         z_q <= '0;
                     else if (bus_io.y[WIDTH-1]) z_q <= $signed(ZW'(0) - sat_mag);
                     else                        z_q <= $signed(sat_mag);
                  end
               end
            end
            DIV: begin
               rem_q <= step_rem;
               dvd_q <= quo_next;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  x_zero_q <= 1'b0;
                  x_neg_q  <= xs_q;
                  y_neg_q  <= ys_q;
                  z_q      <= (xs_q ^ ys_q) ? $signed(ZW'(0) - mag_ext) : $signed(mag_ext);
               end
            end
            default: ;
         endcase
      end
   end
endmodule
`default_nettype wire
